// File: rtl/stepdown_discharge_seq.sv
// Step-down discharge sequencer.
// Per channel: two async inputs are synchronized and debounced, NANDed into a
// registered output o. A 0->1 transition of o[k] (or a force request) queues
// channel k for a discharge pulse. A single round-robin FSM serves the queue,
// one channel at a time, with a one-cycle break-before-make gap after each pulse.

// One input bit: 2-flop synchronizer followed by a debounce filter.
module stepdown_discharge_seq_filt #(
  parameter int DB_CYC = 4,
  parameter int CW     = $clog2(DB_CYC + 1)
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic f
);
  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // Metastability guard for the asynchronous input.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync <= '0;
    else       sync <= {sync[0], d};
  end

  // Filtered copy follows only after DB_CYC consecutive differing cycles;
  // any agreeing cycle restarts the count, so the counter never wraps.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      f   <= 1'b0;
      cnt <= '0;
    end else if (sync[1] == f) begin
      cnt <= '0;
    end else if (cnt == CW'(DB_CYC - 1)) begin
      f   <= sync[1];
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module stepdown_discharge_seq #(
  parameter int NCH     = 4,
  parameter int DB_CYC  = 4,
  parameter int DIS_CYC = 16
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           CELV,
  input  logic           CELG,
  input  logic           SUB,
  input  logic [NCH-1:0] i0,
  input  logic [NCH-1:0] i1,
  input  logic           frc,
  output logic [NCH-1:0] o,
  output logic [NCH-1:0] dis,
  output logic           busy
);
  localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int DW = $clog2(DIS_CYC + 1);

  typedef enum logic [1:0] {IDLE, DISCH, GAP} state_t;

  // Power/substrate pins carry no logic.
  logic unused_pwr;
  assign unused_pwr = ^{CELV, CELG, SUB};

  logic [NCH-1:0] f0, f1, o_nxt, set, clr, pending, dis_nxt;
  logic           frc_d, found;
  logic [PW-1:0]  ptr, ptr_nxt, sel, sel_nxt, pick;
  logic [DW-1:0]  dcnt, dcnt_nxt;
  state_t         state, state_nxt;

  stepdown_discharge_seq_filt #(.DB_CYC(DB_CYC)) u_f0 [NCH-1:0] (
    .clk(clk), .rstn(rstn), .d(i0), .f(f0));
  stepdown_discharge_seq_filt #(.DB_CYC(DB_CYC)) u_f1 [NCH-1:0] (
    .clk(clk), .rstn(rstn), .d(i1), .f(f1));

  // Rising o, or a force edge on channels already high, request a discharge.
  // Filters reset to 0 so o_nxt is all-ones out of reset: no false rise.
  assign o_nxt = ~(f0 & f1);
  assign set   = (o_nxt & ~o) | ((frc & ~frc_d) ? o : '0);

  // Output register, force edge detector and pending set/clear (clear wins,
  // so a request landing on the channel being finished does not restart it).
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o       <= '1;
      frc_d   <= 1'b0;
      pending <= '0;
    end else begin
      o       <= o_nxt;
      frc_d   <= frc;
      pending <= (pending | set) & ~clr;
    end
  end

  // Round-robin pick: first pending channel at or after ptr, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = ptr;
    for (int i = 0; i < NCH; i++) begin
      if (!found && pending[(int'(ptr) + i) % NCH]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr) + i) % NCH);
      end
    end
  end

  // Discharge FSM: next state, next dis, pending clears.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    dcnt_nxt  = dcnt;
    dis_nxt   = '0;
    clr       = '0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt     = DISCH;
          sel_nxt       = pick;
          dcnt_nxt      = DW'(1);
          dis_nxt[pick] = 1'b1;
        end
      end
      DISCH: begin
        if (!o[sel]) begin
          // Channel re-enabled mid-pulse: abort, leave ptr where it was.
          clr[sel]  = 1'b1;
          state_nxt = GAP;
        end else if (dcnt == DW'(DIS_CYC)) begin
          clr[sel]  = 1'b1;
          ptr_nxt   = (sel == PW'(NCH - 1)) ? '0 : sel + 1'b1;
          state_nxt = GAP;
        end else begin
          dcnt_nxt     = dcnt + 1'b1;
          dis_nxt[sel] = 1'b1;
        end
      end
      GAP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM registers; dis and busy come straight from flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      sel   <= '0;
      ptr   <= '0;
      dcnt  <= '0;
      dis   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      dcnt  <= dcnt_nxt;
      dis   <= dis_nxt;
      busy  <= (state != IDLE) || (|pending);
    end
  end
endmodule

// File: tb/tb_stepdown_discharge_seq.sv
// Randomized bench for stepdown_discharge_seq. The stimulus side predicts the
// sequence of discharge pulses (channel, full or aborted) into a queue; a
// monitor measures each pulse on dis and checks it against the queue head.
module tb_stepdown_discharge_seq;
  localparam int NCH = 4, DB_CYC = 4, DIS_CYC = 16;

  typedef struct { int ch; bit abort; } exp_t;

  logic clk = 0, rstn = 0, frc = 0;
  logic [NCH-1:0] i0 = '0, i1 = '0, o, dis;
  logic busy;

  int compared = 0, mismatched = 0, cyc = 0;
  exp_t q[$];
  logic [NCH-1:0] om;   // model of o
  int ptr_m;            // model round-robin pointer

  stepdown_discharge_seq #(.NCH(NCH), .DB_CYC(DB_CYC), .DIS_CYC(DIS_CYC)) dut (
    .clk(clk), .rstn(rstn), .CELV(1'b1), .CELG(1'b0), .SUB(1'b0),
    .i0(i0), .i1(i1), .frc(frc), .o(o), .dis(dis), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Channels in 'set' are served in round-robin order starting at ptr_m.
  task automatic push_rr(input logic [NCH-1:0] set);
    int c, last;
    last = -1;
    for (int j = 0; j < NCH; j++) begin
      c = (ptr_m + j) % NCH;
      if (set[c]) begin q.push_back('{c, 1'b0}); last = c; end
    end
    if (last >= 0) ptr_m = (last + 1) % NCH;
  endtask

  // Drive a new stable input pattern; o must update exactly DB_CYC+3 edges on.
  task automatic apply(input logic [NCH-1:0] a, input logic [NCH-1:0] b);
    logic [NCH-1:0] onew;
    onew = ~(a & b);
    @(negedge clk); i0 = a; i1 = b;
    push_rr(onew & ~om);
    repeat (DB_CYC + 2) @(posedge clk);
    @(negedge clk); chk("o_before_latency", 32'(o), 32'(om));
    @(posedge clk);
    @(negedge clk); chk("o_at_latency", 32'(o), 32'(onew));
    om = onew;
  endtask

  task automatic waitidle();
    int n;
    n = 0;
    repeat (3) @(negedge clk);
    while ((q.size() != 0 || busy) && n < 600) begin @(negedge clk); n++; end
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_queue_empty", 32'(q.size()), 32'd0);
    q.delete();
  endtask

  task automatic force_pulse();
    @(negedge clk); frc = 1;
    push_rr(om);
    @(negedge clk); frc = 0;
  endtask

  task automatic pick_low(output int c);
    int s;
    c = -1;
    s = $urandom_range(0, NCH - 1);
    for (int j = 0; j < NCH; j++)
      if (c < 0 && !om[(s + j) % NCH]) c = (s + j) % NCH;
  endtask

  // Short drop of i1 on a low-o channel must be filtered out entirely.
  task automatic glitch(input int c, input int g);
    @(negedge clk); i1[c] = 1'b0;
    repeat (g) @(negedge clk);
    i1[c] = 1'b1;
    repeat (DB_CYC + 12) @(negedge clk);
    chk("glitch_o", 32'(o), 32'(om));
    chk("glitch_busy", 32'(busy), 32'd0);
  endtask

  // Raise o[c], then re-enable the channel at cycle 5 of its pulse.
  task automatic abort_ch(input int c);
    int n;
    @(negedge clk); i1[c] = 1'b0;
    q.push_back('{c, 1'b1});
    n = 0;
    while (!dis[c] && n < 60) begin @(negedge clk); n++; end
    chk("abort_pulse_seen", 32'(dis[c]), 32'd1);
    repeat (4) @(negedge clk);
    i1[c] = 1'b1;
    waitidle();
    chk("abort_o", 32'(o), 32'(om));
  endtask

  task automatic reset_mid_pulse();
    int n;
    apply(NCH'($urandom), '0);
    waitidle();
    force_pulse();
    n = 0;
    while (dis == '0 && n < 20) begin @(negedge clk); n++; end
    chk("rst_pulse_started", 32'(dis != '0), 32'd1);
    repeat (3) @(negedge clk);
    #1 rstn = 0;
    #1;
    chk("rst_async_dis", 32'(dis), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_o", 32'(o), 32'(NCH'('1)));
    q.delete();
    ptr_m = 0;
    repeat (2) @(negedge clk);
    #1 rstn = 1;
    om = ~(i0 & i1);
    repeat (DB_CYC + 30) @(negedge clk);
    chk("post_rst_o", 32'(o), 32'(om));
    chk("post_rst_dis", 32'(dis), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
  endtask

  // Monitor: measures pulses, checks one-hot and break-before-make.
  logic [NCH-1:0] prev_dis = '0, prev_o = '1;
  int ofall[NCH];
  int pstart = 0, pch = -1;
  always @(negedge clk) begin
    if (!rstn) begin
      prev_dis = '0; prev_o = '1; pch = -1;
    end else begin
      if (dis != '0) begin
        compared++;
        if ($countones(dis) != 1 || (prev_dis != '0 && dis != prev_dis)) begin
          mismatched++;
          $display("FAIL dis_onehot_bbm got=%b prev=%b t=%0t", dis, prev_dis, $time);
        end
      end
      for (int k = 0; k < NCH; k++) if (prev_o[k] && !o[k]) ofall[k] = cyc;
      if (prev_dis == '0 && dis != '0) begin
        pstart = cyc;
        for (int k = 0; k < NCH; k++) if (dis[k]) pch = k;
      end
      if (prev_dis != '0 && dis == '0) begin
        compared++;
        if (q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected_pulse ch=%0d want=none", pch);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.ch != pch) begin
            mismatched++;
            $display("FAIL pulse_channel got=%0d want=%0d", pch, e.ch);
          end else if (!e.abort && cyc - pstart != DIS_CYC) begin
            mismatched++;
            $display("FAIL pulse_length ch=%0d got=%0d want=%0d", pch, cyc - pstart, DIS_CYC);
          end else if (e.abort && cyc != ofall[pch] + 1) begin
            mismatched++;
            $display("FAIL abort_timing ch=%0d end=%0d want=%0d", pch, cyc, ofall[pch] + 1);
          end
        end
      end
      prev_dis = dis; prev_o = o;
    end
  end

  initial begin
    int c, op;
    om = '1; ptr_m = 0;
    repeat (3) @(negedge clk);
    chk("rst_o", 32'(o), 32'(NCH'('1)));
    chk("rst_dis", 32'(dis), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #1 rstn = 1;
    repeat (10) @(negedge clk);
    chk("no_pending_out_of_reset", 32'(busy), 32'd0);

    apply(4'b0001, 4'b0001); waitidle();     // o[0] falls
    apply(4'b0001, 4'b0000); waitidle();     // o[0] rises -> ch0 pulse
    apply(4'b1111, 4'b1111); waitidle();
    glitch(2, 3);
    apply(4'b1111, 4'b1101); waitidle();     // ch1 pulse, ptr -> 2
    apply(4'b1111, 4'b1111); waitidle();
    apply(4'b1111, 4'b0101); waitidle();     // ch3 then ch1
    apply(4'b1111, 4'b1111); waitidle();
    abort_ch(0);
    apply(4'b1111, 4'b0100); waitidle();     // o = 1011
    force_pulse(); waitidle();               // channels 0,1,3 again

    for (int it = 0; it < 18; it++) begin
      op = $urandom_range(0, 3);
      pick_low(c);
      if (op == 1) begin force_pulse(); waitidle(); end
      else if (op == 2 && c >= 0) glitch(c, $urandom_range(1, DB_CYC - 1));
      else if (op == 3 && c >= 0) abort_ch(c);
      else begin apply(NCH'($urandom), NCH'($urandom)); waitidle(); end
    end

    reset_mid_pulse();
    apply(NCH'($urandom), NCH'($urandom)); waitidle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
